// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared types and helpers for the PISO serializer
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Which bit of the parallel word goes out as serial bit k.
    function automatic int bit_index(input int k, input int width, input bit msb_first);
        return msb_first ? (width - 1 - k) : k;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mux2_1.sv
// rtl/mux2_1.sv - single-bit 2:1 multiplexer primitive
module mux2_1 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_dff_cell.sv
// rtl/mux_dff_cell.sv - one storage bit with enable and sync clear built from mux2_1
module mux_dff_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    logic hold_or_load;
    logic next_q;

    mux2_1 u_en_mux (
        .d0  (q),
        .d1  (d),
        .sel (en),
        .y   (hold_or_load)
    );

    mux2_1 u_rst_mux (
        .d0  (hold_or_load),
        .d1  (1'b0),
        .sel (rst),
        .y   (next_q)
    );

    always_ff @(posedge clk) begin
        q <= next_q;
    end

endmodule

// File: rtl/piso_serializer_mux.sv
// rtl/piso_serializer_mux.sv - parallel-in serial-out transmitter with gapless streaming
module piso_serializer_mux
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] load_word;
    logic             load;
    logic             shift_en;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
    assign in_ready = !rst && ((state_q == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;

    // The word is reordered at load so the register always shifts toward bit 0.
    for (genvar k = 0; k < WIDTH; k++) begin : g_bits
        logic shift_in;

        assign load_word[k] = in_data[bit_index(k, WIDTH, MSB_FIRST)];

        if (k == WIDTH - 1) begin : g_top
            assign shift_in = 1'b0;
        end else begin : g_mid
            assign shift_in = sr_q[k+1];
        end

        mux2_1 u_sel (
            .d0  (shift_in),
            .d1  (load_word[k]),
            .sel (load),
            .y   (sr_d[k])
        );

        mux_dff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .en  (load | shift_en),
            .d   (sr_d[k]),
            .q   (sr_q[k])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign ser_out   = ser_valid ? sr_q[0] : IDLE_LEVEL;
    assign done      = done_q;

endmodule
